// File: rtl/ws2812_cmd_parser_if.sv
// Host byte-stream handshake into the WS2812 command parser.
// master drives rx_valid/rx_data, slave returns rx_ready.
interface ws2812_cmd_parser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );
endinterface

// File: rtl/ws2812_cmd_parser.sv
// Byte-stream command parser driving WS2812 override and strip writes.
// Ports: clk_g, rst, rx (stream slave), override_*, strip_*, pulses, busy.
module ws2812_cmd_parser #(
  parameter int CLK_HZ     = 27_000_000,
  parameter int LED_COUNT  = 150,
  parameter int TIMEOUT_US = 1000
) (
  input  logic                      clk_g,
  input  logic                      rst,
  ws2812_cmd_parser_if.slave        rx,
  output logic                      override_en,
  output logic [23:0]               override_color_grb,
  output logic [7:0]                override_brightness,
  output logic                      strip_write,
  output logic [15:0]               strip_index,
  output logic [23:0]               strip_color_grb,
  output logic                      activity_pulse,
  output logic                      err_pulse,
  output logic                      busy
);
  localparam int STRIP_COUNT = LED_COUNT - 1;
  localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  localparam logic [16:0]   STRIP_LIM = 17'(STRIP_COUNT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] OP_SET  = 8'h01;
  localparam logic [7:0] OP_CLR  = 8'h02;
  localparam logic [7:0] OP_RUN  = 8'h03;
  localparam logic [7:0] OP_FILL = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    ARGS,
    PIX,
    FILL
  } state_t;

  state_t          state;
  logic [7:0]      op;
  logic [2:0]      argn;
  logic [4:0][7:0] args;
  logic [1:0]      pixn;
  logic [7:0]      pix_g;
  logic [7:0]      pix_r;
  logic [15:0]     idx;
  logic [7:0]      cnt;
  logic [23:0]     fill_grb;
  logic [TW-1:0]   tmo;

  logic       acc;
  logic       wr_ok;
  logic       tmo_hit;
  logic       last_pix;
  logic [2:0] last_argn;

  assign rx.rx_ready = (state != FILL);
  assign busy        = (state != IDLE);
  assign acc         = rx.rx_valid & rx.rx_ready;
  assign wr_ok       = {1'b0, idx} < STRIP_LIM;
  assign tmo_hit     = (tmo == TMO_LAST);
  assign last_pix    = (cnt == 8'd1);

  // index of the final argument byte for the latched opcode
  always_comb begin
    last_argn = 3'd0;
    unique case (1'b1)
      op == OP_SET:  last_argn = 3'd3;
      op == OP_RUN:  last_argn = 3'd2;
      op == OP_FILL: last_argn = 3'd5;
      default:       last_argn = 3'd0;
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (rst) begin
      state               <= IDLE;
      op                  <= '0;
      argn                <= '0;
      args                <= '0;
      pixn                <= '0;
      pix_g               <= '0;
      pix_r               <= '0;
      idx                 <= '0;
      cnt                 <= '0;
      fill_grb            <= '0;
      tmo                 <= '0;
      override_en         <= 1'b0;
      override_color_grb  <= '0;
      override_brightness <= '0;
      strip_write         <= 1'b0;
      strip_index         <= '0;
      strip_color_grb     <= '0;
      activity_pulse      <= 1'b0;
      err_pulse           <= 1'b0;
    end else begin
      strip_write    <= 1'b0;
      activity_pulse <= 1'b0;
      err_pulse      <= 1'b0;
      unique case (state)
        IDLE: begin
          tmo  <= '0;
          argn <= '0;
          if (acc) begin
            unique case (1'b1)
              rx.rx_data == OP_SET,
              rx.rx_data == OP_RUN,
              rx.rx_data == OP_FILL: begin
                op    <= rx.rx_data;
                state <= ARGS;
              end
              rx.rx_data == OP_CLR: begin
                override_en    <= 1'b0;
                activity_pulse <= 1'b1;
              end
              default: err_pulse <= 1'b1;
            endcase
          end
        end
        ARGS: begin
          if (acc) begin
            tmo  <= '0;
            argn <= argn + 3'd1;
            if (argn < 3'd5) args[argn] <= rx.rx_data;
            if (argn == last_argn) begin
              argn <= '0;
              unique case (1'b1)
                op == OP_SET: begin
                  override_en         <= 1'b1;
                  override_color_grb  <= {args[0], args[1], args[2]};
                  override_brightness <= rx.rx_data;
                  activity_pulse      <= 1'b1;
                  state               <= IDLE;
                end
                op == OP_RUN: begin
                  idx  <= {args[0], args[1]};
                  cnt  <= rx.rx_data;
                  pixn <= '0;
                  if (rx.rx_data == 8'd0) begin
                    activity_pulse <= 1'b1;
                    state          <= IDLE;
                  end else begin
                    state <= PIX;
                  end
                end
                default: begin
                  idx      <= {args[0], args[1]};
                  cnt      <= args[2];
                  fill_grb <= {args[3], args[4], rx.rx_data};
                  if (args[2] == 8'd0) begin
                    activity_pulse <= 1'b1;
                    state          <= IDLE;
                  end else begin
                    state <= FILL;
                  end
                end
              endcase
            end
          end else if (tmo_hit) begin
            tmo       <= '0;
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        PIX: begin
          if (acc) begin
            tmo <= '0;
            unique case (pixn)
              2'd0: begin
                pix_g <= rx.rx_data;
                pixn  <= 2'd1;
              end
              2'd1: begin
                pix_r <= rx.rx_data;
                pixn  <= 2'd2;
              end
              default: begin
                pixn <= '0;
                if (wr_ok) begin
                  strip_write     <= 1'b1;
                  strip_index     <= idx;
                  strip_color_grb <= {pix_g, pix_r, rx.rx_data};
                end
                idx <= idx + 16'd1;
                cnt <= cnt - 8'd1;
                if (last_pix) begin
                  activity_pulse <= 1'b1;
                  state          <= IDLE;
                end
              end
            endcase
          end else if (tmo_hit) begin
            tmo       <= '0;
            err_pulse <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FILL: begin
          tmo <= '0;
          if (wr_ok) begin
            strip_write     <= 1'b1;
            strip_index     <= idx;
            strip_color_grb <= fill_grb;
          end
          idx <= idx + 16'd1;
          cnt <= cnt - 8'd1;
          if (last_pix) begin
            activity_pulse <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_cmd_parser.sv
// Randomized + directed bench for ws2812_cmd_parser.
// Command-level model schedules expected outputs by cycle number.
module tb_ws2812_cmd_parser;
  localparam int T      = 40;
  localparam int LEDS   = 150;
  localparam int STRIPN = LEDS - 1;

  logic clk_g = 1'b0;
  logic rst   = 1'b1;

  ws2812_cmd_parser_if ifc ();

  logic        override_en;
  logic [23:0] override_color_grb;
  logic [7:0]  override_brightness;
  logic        strip_write;
  logic [15:0] strip_index;
  logic [23:0] strip_color_grb;
  logic        activity_pulse;
  logic        err_pulse;
  logic        busy;

  ws2812_cmd_parser #(
    .CLK_HZ    (1_000_000),
    .LED_COUNT (LEDS),
    .TIMEOUT_US(T)
  ) dut (
    .clk_g              (clk_g),
    .rst                (rst),
    .rx                 (ifc),
    .override_en        (override_en),
    .override_color_grb (override_color_grb),
    .override_brightness(override_brightness),
    .strip_write        (strip_write),
    .strip_index        (strip_index),
    .strip_color_grb    (strip_color_grb),
    .activity_pulse     (activity_pulse),
    .err_pulse          (err_pulse),
    .busy               (busy)
  );

  always #5 clk_g = ~clk_g;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // model: bytes of the command in progress, writes/activity keyed by cycle
  int          n    = 0;
  int          fle  = 0;
  int          idle = 0;
  bit          armed = 0;
  logic [7:0]  q[$];
  logic [39:0] wsch[int];
  bit          asch[int];
  bit          m_acc;
  logic [15:0] m_base;
  logic [15:0] m_ix;
  int          m_cnt;
  int          m_k;

  bit          e_wr, e_act, e_err, e_busy, e_ready, e_ov_en;
  logic [15:0] e_idx;
  logic [23:0] e_col;
  logic [23:0] e_ov_col;
  logic [7:0]  e_ov_bri;

  always @(posedge clk_g) begin
    n++;
    e_wr  = 0;
    e_act = 0;
    e_err = 0;
    if (rst) begin
      q.delete();
      wsch.delete();
      asch.delete();
      fle      = 0;
      idle     = 0;
      e_ov_en  = 0;
      e_ov_col = '0;
      e_ov_bri = '0;
      e_idx    = '0;
      e_col    = '0;
      armed    = 1;
    end else begin
      m_acc = ifc.rx_valid && (n > fle);
      if (m_acc) begin
        idle = 0;
        q.push_back(ifc.rx_data);
        case (q[0])
          8'h01: if (q.size() == 5) begin
            e_ov_en  = 1;
            e_ov_col = {q[1], q[2], q[3]};
            e_ov_bri = q[4];
            e_act    = 1;
            q.delete();
          end
          8'h02: begin
            e_ov_en = 0;
            e_act   = 1;
            q.delete();
          end
          8'h03: if (q.size() >= 4) begin
            m_base = {q[1], q[2]};
            m_cnt  = int'(q[3]);
            if (m_cnt == 0) begin
              e_act = 1;
              q.delete();
            end else if (q.size() > 4 && (q.size() - 4) % 3 == 0) begin
              m_k  = (q.size() - 4) / 3 - 1;
              m_ix = m_base + 16'(m_k);
              if (int'(m_ix) < STRIPN)
                wsch[n] = {m_ix, q[q.size()-3], q[q.size()-2], q[q.size()-1]};
              if (m_k == m_cnt - 1) begin
                e_act = 1;
                q.delete();
              end
            end
          end
          8'h04: if (q.size() == 7) begin
            m_base = {q[1], q[2]};
            m_cnt  = int'(q[3]);
            for (int j = 0; j < m_cnt; j++) begin
              m_ix = m_base + 16'(j);
              if (int'(m_ix) < STRIPN)
                wsch[n+1+j] = {m_ix, q[4], q[5], q[6]};
            end
            if (m_cnt == 0) e_act = 1;
            else begin
              asch[n+m_cnt] = 1;
              fle = n + m_cnt;
            end
            q.delete();
          end
          default: begin
            e_err = 1;
            q.delete();
          end
        endcase
      end else if (q.size() > 0) begin
        idle++;
        if (idle == T) begin
          e_err = 1;
          q.delete();
        end
      end
    end
    if (wsch.exists(n)) begin
      e_wr  = 1;
      e_idx = wsch[n][39:24];
      e_col = wsch[n][23:0];
      wsch.delete(n);
    end
    if (asch.exists(n)) begin
      e_act = 1;
      asch.delete(n);
    end
    e_busy  = (q.size() > 0) || (n < fle);
    e_ready = !(n < fle);
  end

  logic [40:0] obs_w[$];
  int          obs_err = 0;
  int          obs_act = 0;

  always @(negedge clk_g) begin
    if (armed) begin
      chk("rx_ready", 64'(ifc.rx_ready), 64'(e_ready));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("strip_write", 64'(strip_write), 64'(e_wr));
      chk("strip_index", 64'(strip_index), 64'(e_idx));
      chk("strip_color", 64'(strip_color_grb), 64'(e_col));
      chk("activity", 64'(activity_pulse), 64'(e_act));
      chk("err_pulse", 64'(err_pulse), 64'(e_err));
      chk("ovr_en", 64'(override_en), 64'(e_ov_en));
      chk("ovr_color", 64'(override_color_grb), 64'(e_ov_col));
      chk("ovr_bri", 64'(override_brightness), 64'(e_ov_bri));
      if (strip_write === 1'b1)
        obs_w.push_back({strip_index, strip_color_grb, activity_pulse});
      if (err_pulse === 1'b1) obs_err++;
      if (activity_pulse === 1'b1) obs_act++;
    end
  end

  logic [7:0] sq[$];

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk_g);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    k = 0;
    while (ifc.rx_ready !== 1'b1 && k < 500) begin
      @(negedge clk_g);
      k++;
    end
    if (k >= 500) chk("ready_wait", 64'(ifc.rx_ready), 64'(1));
    @(posedge clk_g);
  endtask

  task automatic idle_cyc(input int c);
    @(negedge clk_g);
    ifc.rx_valid = 1'b0;
    repeat (c - 1) @(negedge clk_g);
  endtask

  task automatic send_q(input bit gaps);
    foreach (sq[i]) begin
      send_byte(sq[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: idle_cyc(T - 1);
          1: idle_cyc(T);
          default: idle_cyc($urandom_range(1, 4));
        endcase
      end
    end
  endtask

  function automatic logic [15:0] pick_idx();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(0, 20));
      1: return 16'($urandom_range(140, 155));
      2: return 16'($urandom_range(16'hFFFD, 16'hFFFF));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  int rl;
  int cut;
  logic [15:0] rb;
  int rc;

  initial begin
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_g);
    rst = 1'b0;
    chk("rst_ready", 64'(ifc.rx_ready), 64'(1));
    chk("rst_index", 64'(strip_index), 64'(0));
    chk("rst_ovr_en", 64'(override_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    sq = '{8'h01, 8'h0A, 8'h14, 8'h1E, 8'h80};
    send_q(0);
    idle_cyc(1);
    chk("set_en", 64'(override_en), 64'(1));
    chk("set_color", 64'(override_color_grb), 64'(24'h0A141E));
    chk("set_bri", 64'(override_brightness), 64'(8'h80));
    chk("set_act", 64'(activity_pulse), 64'(1));
    sq = '{8'h02};
    send_q(0);
    idle_cyc(1);
    chk("clr_en", 64'(override_en), 64'(0));
    chk("clr_color", 64'(override_color_grb), 64'(24'h0A141E));

    obs_w.delete();
    sq = '{8'h03, 8'h00, 8'h05, 8'h02, 8'hFF, 8'h00, 8'h00,
           8'h00, 8'h00, 8'hFF};
    send_q(0);
    idle_cyc(3);
    chk("run_nwr", 64'(obs_w.size()), 64'(2));
    if (obs_w.size() == 2) begin
      chk("run_w0", 64'(obs_w[0]), 64'({16'd5, 24'hFF0000, 1'b0}));
      chk("run_w1", 64'(obs_w[1]), 64'({16'd6, 24'h0000FF, 1'b1}));
    end

    obs_w.delete();
    obs_act = 0;
    sq = '{8'h04, 8'h00, 8'h94, 8'h03, 8'h01, 8'h02, 8'h03};
    send_q(0);
    idle_cyc(1);
    rl = 0;
    repeat (8) begin
      if (ifc.rx_ready === 1'b0) rl++;
      @(negedge clk_g);
    end
    chk("fill_ready_low", 64'(rl), 64'(3));
    chk("fill_nwr", 64'(obs_w.size()), 64'(1));
    chk("fill_nact", 64'(obs_act), 64'(1));
    if (obs_w.size() == 1)
      chk("fill_w0", 64'(obs_w[0]), 64'({16'd148, 24'h010203, 1'b0}));

    obs_w.delete();
    obs_err = 0;
    sq = '{8'h03, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
    send_q(0);
    idle_cyc(T + 3);
    chk("tmo_nerr", 64'(obs_err), 64'(1));
    chk("tmo_nwr", 64'(obs_w.size()), 64'(0));
    chk("tmo_busy", 64'(busy), 64'(0));
    sq = '{8'h02};
    send_q(0);
    idle_cyc(1);
    chk("tmo_next_act", 64'(activity_pulse), 64'(1));

    sq = '{8'h7E};
    send_q(0);
    idle_cyc(1);
    chk("badop_err", 64'(err_pulse), 64'(1));
    chk("badop_busy", 64'(busy), 64'(0));
    idle_cyc(1);
    chk("badop_err_off", 64'(err_pulse), 64'(0));

    obs_w.delete();
    sq = '{8'h04, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_q(0);
    idle_cyc(6);
    chk("wrap_nwr", 64'(obs_w.size()), 64'(1));
    if (obs_w.size() == 1)
      chk("wrap_w0", 64'(obs_w[0]), 64'({16'h0000, 24'hAABBCC, 1'b1}));

    obs_w.delete();
    sq = '{8'h04, 8'h00, 8'h00, 8'h0A, 8'h01, 8'h02, 8'h03};
    send_q(0);
    @(negedge clk_g);
    ifc.rx_valid = 1'b0;
    @(negedge clk_g);
    rst = 1'b1;
    @(negedge clk_g);
    rst = 1'b0;
    chk("abort_write", 64'(strip_write), 64'(0));
    chk("abort_index", 64'(strip_index), 64'(0));
    chk("abort_color", 64'(strip_color_grb), 64'(0));
    chk("abort_ready", 64'(ifc.rx_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    idle_cyc(12);
    chk("abort_nwr", 64'(obs_w.size()), 64'(1));

    for (int t = 0; t < 300; t++) begin
      sq.delete();
      case ($urandom_range(0, 9))
        0: sq.push_back(8'h02);
        1, 2: begin
          sq.push_back(8'h01);
          repeat (4) sq.push_back(8'($urandom_range(0, 255)));
        end
        3, 4, 5: begin
          rb = pick_idx();
          rc = $urandom_range(0, 4);
          sq.push_back(8'h03);
          sq.push_back(rb[15:8]);
          sq.push_back(rb[7:0]);
          sq.push_back(8'(rc));
          repeat (3 * rc) sq.push_back(8'($urandom_range(0, 255)));
        end
        6, 7, 8: begin
          rb = pick_idx();
          sq.push_back(8'h04);
          sq.push_back(rb[15:8]);
          sq.push_back(rb[7:0]);
          sq.push_back(8'($urandom_range(0, 6)));
          repeat (3) sq.push_back(8'($urandom_range(0, 255)));
        end
        default: begin
          rc = $urandom_range(0, 255);
          if (rc >= 1 && rc <= 4) rc = 8'h7E;
          sq.push_back(8'(rc));
        end
      endcase
      if (sq.size() > 1 && $urandom_range(0, 11) == 0) begin
        cut = $urandom_range(1, sq.size() - 1);
        while (sq.size() > cut) void'(sq.pop_back());
        send_q(1);
        idle_cyc(T + 2);
      end else begin
        send_q(1);
      end
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk_g);
        rst = 1'b1;
        ifc.rx_valid = 1'($urandom_range(0, 1));
        ifc.rx_data  = 8'($urandom_range(0, 255));
        @(negedge clk_g);
        rst = 1'b0;
        ifc.rx_valid = 1'b0;
      end
    end
    idle_cyc(T + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
